lane_input_conditioner: RTL and testbench
=========================================

Name: lane_input_conditioner

Overview:
- Sits directly upstream of the player drawing block. Turns the two raw, asynchronous, bouncy push-button inputs (left/right) into clean `move_left`/`move_right` levels.
- Processing chain: synchronise, debounce, then arbitrate between the two keys.
- Output is a level held for the whole press. The player block consumes it with its own press/release re-arm logic, so one physical press produces exactly one lane change.
- Also emits one-cycle press pulses for other consumers (score, sound).

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised level must stay stable before it is accepted (20 ms at 50 MHz); must be >= 2.
- CNT_W, 20, width of the debounce and repeat counters; must hold DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_GAP.
- KEY_ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed (board KEYs); 0 = active-high.
- REPEAT_DELAY, 1000000, with HOLD_REPEAT_EN: held cycles before each repeat gap starts.
- REPEAT_GAP, 16384, with HOLD_REPEAT_EN: cycles the output drops during a repeat. Must exceed one full player erase+draw pass (7200 cycles).

Ports:
- Clock  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- key_left_raw  input  1  raw left button, asynchronous.
- key_right_raw  input  1  raw right button, asynchronous.
- move_left  output  1  level, high while a valid left press is held.
- move_right  output  1  level, high while a valid right press is held.
- left_pulse  output  1  one-cycle pulse on each move_left rising edge.
- right_pulse  output  1  one-cycle pulse on each move_right rising edge.

Behaviour:
- Reset is sampled on the Clock edge and must be held for at least 1 cycle. Reset mid-operation takes effect on the next edge and overrides everything.
- Reset values:
  - All outputs 0.
  - Sync flops at the "released" level.
  - Debounced levels = released.
  - Counters 0.
  - FSM in S_IDLE.
- Polarity: a raw key is normalised to "pressed = 1" via KEY_ACTIVE_LOW before synchronisation.
- Synchroniser: 2 flip-flops per key. Nothing downstream uses the first stage.
- Debouncer (per key):
  - Counter increments each cycle the synchronised level differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - Any cycle where the two levels match clears the counter. Glitches shorter than DEBOUNCE_CYCLES cycles are therefore discarded.
  - Counter saturates and never wraps.
- Arbitration FSM (states S_IDLE, S_LEFT, S_RIGHT, S_LOCK), evaluated on debounced levels dl/dr:
  - S_IDLE: dl&!dr -> S_LEFT; dr&!dl -> S_RIGHT; dl&dr (same cycle) -> S_LOCK; else stay.
  - S_LEFT: !dl -> S_IDLE; dr -> S_LOCK (second key while first is held).
  - S_RIGHT: mirror of S_LEFT.
  - S_LOCK: both outputs 0 until dl=0 and dr=0, then -> S_IDLE. A lone key left held after the other releases does not re-fire.
- Outputs are registered Moore outputs:
  - move_left=1 exactly while in S_LEFT; move_right=1 exactly while in S_RIGHT.
  - The two are never high simultaneously.
- Pulses: left_pulse is high for the single cycle in which move_left goes 0->1; right_pulse likewise.
- Latency: a clean raw press stable from edge k asserts move_x after edge k+DEBOUNCE_CYCLES+3. Release has the same latency.

Optional Feature:
- Macro: LANE_INPUT_HOLD_REPEAT_EN.
- Defined:
  - A repeat counter clears on entry to S_LEFT/S_RIGHT and counts while the key is held.
  - At REPEAT_DELAY the output drops to 0 for REPEAT_GAP cycles, then reasserts (firing a pulse again); the cycle repeats while the key is held.
  - Release or lockout during the gap behaves as normal (-> S_IDLE / S_LOCK), outputs stay 0, and the counter clears.
- Undefined: no repeat logic. The output stays high for the entire hold.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=40, REPEAT_GAP=10, KEY_ACTIVE_LOW=1):
- Reset held 3 cycles with keys at 1 -> all outputs 0, no pulses for 50 cycles afterward.
- key_left_raw driven 0 at edge 10 and held -> move_left rises after edge 17; left_pulse high exactly that cycle; release at edge 30 -> move_left falls after edge 37.
- key_right_raw bounce (low 2 cycles, high 1, low 1, high 1) then clean low -> no assertion during the bounce; move_right rises 7 cycles after the clean low begins, with a single right_pulse.
- Left held, then right pressed at edge 25 -> move_left drops when dr is debounced; both stay 0; after releasing right only, still 0; after releasing left then pressing left again -> move_left reasserts.
- Both keys pressed in the same cycle -> S_LOCK; zero pulses, both outputs 0 throughout.
- With LANE_INPUT_HOLD_REPEAT_EN, left held 120 cycles -> move_left high 40, low 10, high 40, low 10…; left_pulse on each rise. Without the macro -> a single 120-cycle high and one pulse.

Source files
------------

// File: rtl/lane_input_conditioner.sv
// Push-button front end: polarity normalise, 2-flop sync, debounce, left/right arbitration.
// Define LANE_INPUT_HOLD_REPEAT_EN to make a held key periodically drop and re-raise its move level.
module lane_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 1000000,
  parameter int unsigned REPEAT_GAP      = 16384
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_left_raw,
  input  logic key_right_raw,
  output logic move_left,
  output logic move_right,
  output logic left_pulse,
  output logic right_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || (DEBOUNCE_CYCLES >> CNT_W) != 0 ||
      (REPEAT_DELAY >> CNT_W) != 0 || (REPEAT_GAP >> CNT_W) != 0) begin : g_bad_params
    $error("lane_input_conditioner: DEBOUNCE_CYCLES/REPEAT_* out of range for CNT_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT, S_LOCK} state_t;

  // Bit 0 = left key, bit 1 = right key; 1 means pressed from here on.
  logic [1:0] key_norm;
  logic [1:0] deb;
  logic       dl, dr;
  logic       rep_gap;
  state_t     state;

  assign key_norm = KEY_ACTIVE_LOW ? ~{key_right_raw, key_left_raw}
                                   :  {key_right_raw, key_left_raw};

  for (genvar g = 0; g < 2; g++) begin : g_key
    logic             sync_1, sync_2, level;
    logic [CNT_W-1:0] db_cnt;

    always_ff @(posedge Clock) begin
      if (Reset) begin
        sync_1 <= 1'b0;
        sync_2 <= 1'b0;
        level  <= 1'b0;
        db_cnt <= '0;
      end else begin
        sync_1 <= key_norm[g];
        sync_2 <= sync_1;
        if (sync_2 == level) begin
          db_cnt <= '0;
        end else if (db_cnt >= DB_LAST) begin
          level  <= sync_2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end
    end

    assign deb[g] = level;
  end

  assign dl = deb[0];
  assign dr = deb[1];

`ifdef LANE_INPUT_HOLD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_GAP_LAST   = CNT_W'(REPEAT_GAP - 1);

  logic [CNT_W-1:0] rep_cnt;
  logic             rep_hold;

  // True only while the FSM will stay in its lane state, so entry, release and lockout all clear.
  assign rep_hold = (state == S_LEFT  && dl && !dr) ||
                    (state == S_RIGHT && dr && !dl);

  always_ff @(posedge Clock) begin
    if (Reset || !rep_hold) begin
      rep_cnt <= '0;
      rep_gap <= 1'b0;
    end else if (!rep_gap && rep_cnt >= REP_DELAY_LAST) begin
      rep_cnt <= '0;
      rep_gap <= 1'b1;
    end else if (rep_gap && rep_cnt >= REP_GAP_LAST) begin
      rep_cnt <= '0;
      rep_gap <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt + CNT_W'(1);
    end
  end
`else
  always_comb rep_gap = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_IDLE;
      move_left   <= 1'b0;
      move_right  <= 1'b0;
      left_pulse  <= 1'b0;
      right_pulse <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dl && dr)  state <= S_LOCK;
          else if (dl)   state <= S_LEFT;
          else if (dr)   state <= S_RIGHT;
        end
        S_LEFT: begin
          if (!dl)       state <= S_IDLE;
          else if (dr)   state <= S_LOCK;
        end
        S_RIGHT: begin
          if (!dr)       state <= S_IDLE;
          else if (dl)   state <= S_LOCK;
        end
        S_LOCK: begin
          if (!dl && !dr) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Outputs trail the state register by one cycle; pulses mark the level's rising edge.
      move_left   <= (state == S_LEFT)  && !rep_gap;
      move_right  <= (state == S_RIGHT) && !rep_gap;
      left_pulse  <= (state == S_LEFT)  && !rep_gap && !move_left;
      right_pulse <= (state == S_RIGHT) && !rep_gap && !move_right;
    end
  end

endmodule

// File: tb/tb_lane_input_conditioner.sv
// Directed bench for lane_input_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=40, REPEAT_GAP=10).
module tb_lane_input_conditioner;

  logic Clock = 1'b0;
  logic Reset;
  logic key_left_raw, key_right_raw;
  logic move_left, move_right, left_pulse, right_pulse;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned hi_l, hi_r, pl, pr, cur_run, max_run;
  int unsigned both_total = 0;

  lane_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8),
    .KEY_ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(40),
    .REPEAT_GAP(10)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .key_left_raw(key_left_raw),
    .key_right_raw(key_right_raw),
    .move_left(move_left),
    .move_right(move_right),
    .left_pulse(left_pulse),
    .right_pulse(right_pulse)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    hi_l = 0; hi_r = 0; pl = 0; pr = 0; cur_run = 0; max_run = 0;
  endtask

  // Advance n edges, sampling 1 time unit after each rising edge.
  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
      if (move_left)   hi_l++;
      if (move_right)  hi_r++;
      if (left_pulse)  pl++;
      if (right_pulse) pr++;
      if (move_left && move_right) both_total++;
      cur_run = move_left ? cur_run + 1 : 0;
      if (cur_run > max_run) max_run = cur_run;
    end
  endtask

  initial begin
    Reset = 1'b1; key_left_raw = 1'b1; key_right_raw = 1'b1;
    clear_stats();
    run(3);
    check("rst_move_left",   32'(move_left),   0);
    check("rst_move_right",  32'(move_right),  0);
    check("rst_left_pulse",  32'(left_pulse),  0);
    check("rst_right_pulse", 32'(right_pulse), 0);
    Reset = 1'b0;
    clear_stats();
    run(50);
    check("idle_levels", hi_l + hi_r, 0);
    check("idle_pulses", pl + pr, 0);

    // Clean left press: sampled at edge k, move_left rises after edge k+7.
    clear_stats();
    key_left_raw = 1'b0;
    run(7);
    check("left_before_latency", hi_l, 0);
    run(1);
    check("left_rise",       32'(move_left),  1);
    check("left_pulse_rise", 32'(left_pulse), 1);
    run(1);
    check("left_pulse_one_cycle", 32'(left_pulse), 0);
    clear_stats();
    run(10);
    check("left_hold_level",  hi_l, 10);
    check("left_hold_pulses", pl, 0);
    clear_stats();
    key_left_raw = 1'b1;
    run(7);
    check("left_release_latency", hi_l, 7);
    run(1);
    check("left_fall", 32'(move_left), 0);
    check("left_release_pulses", pl, 0);

    // Right bounce 2 low / 1 high / 1 low / 1 high, then clean low.
    clear_stats();
    key_right_raw = 1'b0; run(2);
    key_right_raw = 1'b1; run(1);
    key_right_raw = 1'b0; run(1);
    key_right_raw = 1'b1; run(1);
    key_right_raw = 1'b0; run(7);
    check("bounce_no_level", hi_r, 0);
    check("bounce_no_pulse", pr, 0);
    run(1);
    check("bounce_right_rise", 32'(move_right), 1);
    check("bounce_pulse_count", pr, 1);
    run(5);
    check("bounce_single_pulse", pr, 1);
    key_right_raw = 1'b1;
    run(12);
    check("right_released", 32'(move_right), 0);

    // Lockout: right pressed while left held.
    key_left_raw = 1'b0;
    run(9);
    check("lock_left_up", 32'(move_left), 1);
    key_right_raw = 1'b0;
    run(7);
    check("lock_left_still_up", 32'(move_left), 1);
    run(1);
    check("lock_left_drop", 32'(move_left), 0);
    clear_stats();
    run(10);
    key_right_raw = 1'b1;
    run(15);
    check("lock_lone_left_quiet", hi_l + hi_r, 0);
    check("lock_lone_left_pulses", pl + pr, 0);
    key_left_raw = 1'b1;
    run(15);
    check("lock_release_quiet", hi_l + hi_r + pl + pr, 0);
    key_left_raw = 1'b0;
    run(8);
    check("lock_rearm_left",  32'(move_left),  1);
    check("lock_rearm_pulse", 32'(left_pulse), 1);
    key_left_raw = 1'b1;
    run(12);

    // Both keys in the same cycle.
    clear_stats();
    key_left_raw = 1'b0; key_right_raw = 1'b0;
    run(25);
    key_left_raw = 1'b1; key_right_raw = 1'b1;
    run(15);
    check("both_levels", hi_l + hi_r, 0);
    check("both_pulses", pl + pr, 0);

    // Reset during a held press.
    key_left_raw = 1'b0;
    run(9);
    check("midrst_left_up", 32'(move_left), 1);
    Reset = 1'b1; key_left_raw = 1'b1;
    run(1);
    check("midrst_left_cleared",  32'(move_left),  0);
    check("midrst_pulse_cleared", 32'(left_pulse), 0);
    run(1);
    Reset = 1'b0;
    clear_stats();
    run(15);
    check("midrst_quiet", hi_l + pl, 0);

    // 120-cycle hold of the left key.
    clear_stats();
    key_left_raw = 1'b0;
    run(120);
    key_left_raw = 1'b1;
    run(20);
`ifdef LANE_INPUT_HOLD_REPEAT_EN
    check("hold_high_cycles", hi_l, 100);
    check("hold_pulses", pl, 3);
    check("hold_longest_run", max_run, 40);
`else
    check("hold_high_cycles", hi_l, 120);
    check("hold_pulses", pl, 1);
    check("hold_longest_run", max_run, 120);
`endif
    check("hold_end_low", 32'(move_left), 0);

    check("never_both_high", both_total, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
